// File: rtl/credit_rx_endpoint.sv
// Receiving end of a credit-based latency-insensitive link.
// Incoming words are buffered in a DEPTH-entry FIFO and presented to the consumer
// with a valid/ready handshake. Each dequeued word returns one credit pulse to the
// sender one cycle after the handshake.
//
// Ports:
//   clock             - single clock, all state on the rising edge
//   reset             - asynchronous, active-high
//   i_data            - payload from the link
//   i_valid           - word present on i_data this cycle
//   o_increment_count - registered credit-return pulse to the sender
//   o_data            - head-of-FIFO word to the consumer (0 when empty)
//   o_valid           - o_data holds a valid word
//   i_ready           - consumer accepts o_data this cycle
//   o_overflow        - sticky: a word arrived while full with no read
module credit_rx_endpoint #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic signed [DATA_WIDTH-1:0] i_data,
    input  logic                         i_valid,
    output logic                         o_increment_count,
    output logic signed [DATA_WIDTH-1:0] o_data,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic                         o_overflow
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic signed [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]              wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]              rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]              count_q, count_d;
    logic                         overflow_q, overflow_d;
    logic                         credit_q;

    logic full;
    logic rd;
    logic wr;
    logic drop;

    assign full = (count_q == CntW'(DEPTH));
    assign rd   = o_valid && i_ready;
    // When full, a simultaneous read frees the slot the write lands in.
    assign wr   = i_valid && (!full || rd);
    assign drop = i_valid && full && !rd;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (wr) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (rd) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        unique case ({wr, rd})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
        if (drop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            credit_q   <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            credit_q   <= rd;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clock) begin
        if (wr) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

    assign o_valid           = (count_q != '0);
    assign o_data            = o_valid ? mem_q[rd_ptr_q] : '0;
    assign o_increment_count = credit_q;
    assign o_overflow        = overflow_q;

endmodule

// File: tb/tb_credit_rx_endpoint.sv
module tb_credit_rx_endpoint;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned DEPTH      = 4;

    logic                         clock   = 1'b0;
    logic                         reset   = 1'b1;
    logic signed [DATA_WIDTH-1:0] i_data  = '0;
    logic                         i_valid = 1'b0;
    logic                         i_ready = 1'b0;
    logic                         o_increment_count;
    logic signed [DATA_WIDTH-1:0] o_data;
    logic                         o_valid;
    logic                         o_overflow;

    credit_rx_endpoint #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .i_data           (i_data),
        .i_valid          (i_valid),
        .o_increment_count(o_increment_count),
        .o_data           (o_data),
        .o_valid          (o_valid),
        .i_ready          (i_ready),
        .o_overflow       (o_overflow)
    );

    always #5 clock = ~clock;

    int n_checks  = 0;
    int n_fail    = 0;
    int pulse_cnt = 0;

    // Behavioural model: a queue of buffered words plus credit and overflow flags.
    int mq[$];
    bit m_cred = 1'b0;
    bit m_ovf  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_cred = 1'b0;
        m_ovf  = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge clock);
            if (reset) begin
                model_clear();
            end else begin
                bit mrd;
                bit mwr;
                mrd = (mq.size() != 0) && (i_ready === 1'b1);
                mwr = (i_valid === 1'b1) && ((mq.size() < DEPTH) || mrd);
                if (mrd) void'(mq.pop_front());
                if (mwr) mq.push_back(int'(i_data));
                else if (i_valid === 1'b1) m_ovf = 1'b1;
                m_cred = mrd;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    initial begin
        forever begin
            @(negedge clock);
            check("o_valid", {31'b0, o_valid}, {31'b0, mq.size() != 0});
            check("o_data", o_data, (mq.size() != 0) ? mq[0] : 0);
            check("o_increment_count", {31'b0, o_increment_count}, {31'b0, m_cred});
            check("o_overflow", {31'b0, o_overflow}, {31'b0, m_ovf});
            if (o_increment_count === 1'b1) pulse_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic fill(input int first, input int n);
        i_ready = 1'b0;
        for (int k = 0; k < n; k++) begin
            i_valid = 1'b1;
            i_data  = first + k;
            step();
        end
        i_valid = 1'b0;
    endtask

    task automatic drain(input string name, input int first, input int n);
        i_ready = 1'b1;
        for (int k = 0; k < n; k++) begin
            check({name, "_valid"}, {31'b0, o_valid}, 32'd1);
            check({name, "_data"}, o_data, first + k);
            step();
        end
        i_ready = 1'b0;
        check({name, "_empty"}, {31'b0, o_valid}, 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_clear();
        step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        logic [31:0] ready_pat;
        int credits;
        int sent;
        int got;
        ready_pat = 32'hB56D_3AE9;

        // 1: reset held with i_valid asserted
        i_valid = 1'b1;
        i_data  = 32'hAAAA_5555;
        i_ready = 1'b1;
        repeat (3) begin
            step();
            check("rst_valid", {31'b0, o_valid}, 32'd0);
            check("rst_data", o_data, 32'd0);
            check("rst_credit", {31'b0, o_increment_count}, 32'd0);
            check("rst_ovf", {31'b0, o_overflow}, 32'd0);
        end
        reset   = 1'b0;
        i_valid = 1'b0;
        repeat (2) begin
            step();
            check("idle_valid", {31'b0, o_valid}, 32'd0);
            check("idle_data", o_data, 32'd0);
        end

        // 2: single word, one-cycle latency, credit one cycle after dequeue
        i_valid = 1'b1;
        i_data  = 32'h1234_5678;
        i_ready = 1'b1;
        step();
        i_valid = 1'b0;
        check("single_valid", {31'b0, o_valid}, 32'd1);
        check("single_data", o_data, 32'h1234_5678);
        check("single_nocredit", {31'b0, o_increment_count}, 32'd0);
        step();
        check("single_empty", {31'b0, o_valid}, 32'd0);
        check("single_credit", {31'b0, o_increment_count}, 32'd1);
        step();
        check("single_credit_end", {31'b0, o_increment_count}, 32'd0);
        i_ready = 1'b0;

        // 3: fill then drain, four back-to-back credits
        fill(1, 4);
        check("fill_head", o_data, 32'd1);
        pulse_cnt = 0;
        drain("fill", 1, 4);
        check("fill_last_credit", {31'b0, o_increment_count}, 32'd1);
        repeat (3) step();
        check("fill_pulses", pulse_cnt, 32'd4);

        // 4: full with simultaneous read and write
        fill(1, 4);
        i_valid = 1'b1;
        i_data  = 5;
        i_ready = 1'b1;
        step();
        i_valid = 1'b0;
        i_ready = 1'b0;
        check("rw_ovf", {31'b0, o_overflow}, 32'd0);
        drain("rw", 2, 4);
        repeat (2) step();

        // 5: overflow drops the word and sticks
        fill(1, 4);
        i_valid = 1'b1;
        i_data  = 9;
        step();
        i_valid = 1'b0;
        check("ovf_set", {31'b0, o_overflow}, 32'd1);
        check("ovf_head", o_data, 32'd1);
        pulse_cnt = 0;
        drain("ovf", 1, 4);
        repeat (3) step();
        check("ovf_pulses", pulse_cnt, 32'd4);
        check("ovf_sticky", {31'b0, o_overflow}, 32'd1);

        // 6: credit-driven stream through pointer wrap, then reset mid-stream
        do_reset();
        check("ovf_cleared", {31'b0, o_overflow}, 32'd0);
        credits   = DEPTH;
        sent      = 0;
        got       = 0;
        pulse_cnt = 0;
        for (int cyc = 0; cyc < 400 && got < 20; cyc++) begin
            i_ready = ready_pat[cyc % 32];
            if (o_valid && i_ready) begin
                check("stream_data", o_data, 100 + got);
                got++;
            end
            if (o_increment_count) credits++;
            if (credits > 0 && sent < 20) begin
                i_valid = 1'b1;
                i_data  = 100 + sent;
                sent++;
                credits--;
            end else begin
                i_valid = 1'b0;
            end
            step();
        end
        i_valid = 1'b0;
        i_ready = 1'b0;
        check("stream_got", got, 32'd20);
        repeat (3) begin
            if (o_increment_count) credits++;
            step();
        end
        check("stream_credits", credits, DEPTH);
        check("stream_pulses", pulse_cnt, 32'd20);
        check("stream_ovf", {31'b0, o_overflow}, 32'd0);

        fill(30, 3);
        i_ready = 1'b1;
        step();
        i_ready = 1'b0;
        check("mid_credit_pending", {31'b0, o_increment_count}, 32'd1);
        check("mid_head", o_data, 32'd31);
        reset = 1'b1;
        model_clear();
        #1;
        check("mid_rst_valid", {31'b0, o_valid}, 32'd0);
        check("mid_rst_credit", {31'b0, o_increment_count}, 32'd0);
        check("mid_rst_data", o_data, 32'd0);
        step();
        reset     = 1'b0;
        pulse_cnt = 0;
        repeat (3) step();
        check("mid_no_pulse", pulse_cnt, 32'd0);
        check("mid_empty", {31'b0, o_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
